// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared constants, FSM state type and address helper for the
// instruction-fetch stage.
package fetch_unit_pkg;

   // Canonical no-op (addi x0, x0, 0) shown whenever the head entry is empty.
   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic {
      BOOT = 1'b0,
      RUN  = 1'b1
   } fetch_state_t;

   // Force a byte address onto a word boundary.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & ~32'h0000_0003;
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry circular prefetch buffer of {pc, instr, filled}.
// Entries are allocated at request grant, filled in order by responses and
// popped from the head; flush empties the buffer in one cycle.
module fetch_queue #(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   alloc,
   input  logic [31:0]            alloc_pc,
   input  logic                   fill,
   input  logic [31:0]            fill_instr,
   input  logic                   pop,
   output logic                   head_filled,
   output logic [31:0]            head_pc,
   output logic [31:0]            head_instr,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0]    alloc_ptr;
   logic [AW-1:0]    fill_ptr;
   logic [AW-1:0]    head_ptr;
   logic [DEPTH-1:0] filled;
   logic [31:0]      pc_mem    [DEPTH];
   logic [31:0]      instr_mem [DEPTH];

   // Pointer, occupancy and filled-flag bookkeeping; flush drops every entry.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      if (rst || flush) begin
         alloc_ptr <= '0;
         fill_ptr  <= '0;
         head_ptr  <= '0;
         filled    <= '0;
         count     <= '0;
      end else begin
         if (alloc) begin
            filled[alloc_ptr] <= 1'b0;
            alloc_ptr         <= alloc_ptr + AW'(1);
         end
         if (fill) begin
            filled[fill_ptr] <= 1'b1;
            fill_ptr         <= fill_ptr + AW'(1);
         end
         if (pop) begin
            filled[head_ptr] <= 1'b0;
            head_ptr         <= head_ptr + AW'(1);
         end
         count <= count + CW'(alloc) - CW'(pop);
      end
   end

   // Payload storage written at allocation (pc) and at response (instr).
   always_ff @(posedge clk) begin
      // NOTE: payload arrays carry no reset; the filled flags and pointers alone decide what is live.
      if (alloc) pc_mem[alloc_ptr]   <= alloc_pc;
      if (fill)  instr_mem[fill_ptr] <= fill_instr;
   end

   assign head_filled = filled[head_ptr];
   assign head_pc     = pc_mem[head_ptr];
   assign head_instr  = instr_mem[head_ptr];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: IF stage. Issues in-order word requests on a grant/response
// instruction bus, buffers returned words in fetch_queue and presents one
// {pc, instr, pc+4} per cycle, honouring stall and EX redirects.
// Optional feature: define FETCH_PERF_EN to build the delivered/bubble counters.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_f_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic        instr_valid_o,
   output logic [31:0] instr_o,
   output logic [31:0] pc_o,
   output logic [31:0] pcplus4_o,
   output logic [31:0] perf_fetched_o,
   output logic [31:0] perf_bubble_o
);

   localparam int            CW   = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   fetch_state_t  state;
   logic [31:0]   fetch_pc;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] outstanding_nxt;
   logic [CW-1:0] drop_cnt;
   logic [CW-1:0] q_count;
   logic          handshake;
   logic          rsp_keep;
   logic          pop;
   logic          head_filled;
   logic [31:0]   head_pc;
   logic [31:0]   head_instr;

   // The outstanding cap also bounds overlap between a draining old stream and new requests.
   assign imem_req_o      = (state == RUN) && (q_count < FULL) && (outstanding < FULL);
   assign imem_addr_o     = fetch_pc;
   assign handshake       = imem_req_o && imem_gnt_i;
   assign rsp_keep        = imem_rvalid_i && (drop_cnt == '0);
   assign pop             = head_filled && !stall_f_i;
   assign outstanding_nxt = outstanding + CW'(handshake) - CW'(imem_rvalid_i);

   fetch_queue #(.DEPTH(DEPTH)) u_queue (
      .clk         (clk),
      .rst         (rst),
      .flush       (redirect_i),
      .alloc       (handshake && !redirect_i),
      .alloc_pc    (fetch_pc),
      .fill        (rsp_keep && !redirect_i),
      .fill_instr  (imem_rdata_i),
      .pop         (pop),
      .head_filled (head_filled),
      .head_pc     (head_pc),
      .head_instr  (head_instr),
      .count       (q_count)
   );

   // BOOT->RUN sequencing, request PC, in-flight count and stale-response drop count.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= BOOT;
         fetch_pc    <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
      end else begin
         case (state)
            BOOT:    state <= RUN;
            RUN:     state <= RUN;
            default: state <= BOOT;
         endcase
         outstanding <= outstanding_nxt;
         if (redirect_i) begin
            // Everything still in flight, including this cycle's grant, is old stream.
            fetch_pc <= word_align(redirect_pc_i);
            drop_cnt <= outstanding_nxt;
         end else begin
            if (handshake) fetch_pc <= fetch_pc + 32'd4;
            if (imem_rvalid_i && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
         end
      end
   end

   // Head presentation; an empty queue shows a NOP at the next fetch address.
   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      instr_valid_o = head_filled;
      instr_o       = NOP_INSTR;
      pc_o          = fetch_pc;
      if (head_filled)     instr_o = head_instr;
      if (q_count != '0)   pc_o    = head_pc;
   end

   assign pcplus4_o = pc_o + 32'd4;

`ifdef FETCH_PERF_EN
   logic [31:0] fetched_q;
   logic [31:0] bubble_q;

   // Delivered-instruction and bubble-cycle counters, wrapping at 32 bits.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetched_q <= '0;
         bubble_q  <= '0;
      end else begin
         if (pop) fetched_q <= fetched_q + 32'd1;
         if (!instr_valid_o && !stall_f_i && !redirect_i) bubble_q <= bubble_q + 32'd1;
      end
   end

   assign perf_fetched_o = fetched_q;
   assign perf_bubble_o  = bubble_q;
`else
   assign perf_fetched_o = '0;
   assign perf_bubble_o  = '0;
`endif

endmodule
